// File: rtl/mem_pkg.sv
// Shared types and defaults for the synchronous data memory block.
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DEPTH    = 256;
  localparam int DEF_LED_W    = 4;
  localparam int DEF_LED_ADDR = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_memory_mmio_ram.sv
// Single-port storage array: registered read, per-byte write mask.
module sync_ram_1p
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset: contents are cleared by the owner's init sequence.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_mmio.sv
// Data memory with zero-init sequencer, range check and LED register.
// Optional macro DATA_MEMORY_BYTE_WRITE_EN adds the byte_en write mask.
module data_memory_mmio
  import mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LED_W    = DEF_LED_W,
  parameter int LED_ADDR = DEF_LED_ADDR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic [ADDR_W-1:0]   location,
  input  logic [DATA_W-1:0]   value,
`ifdef DATA_MEMORY_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] byte_en,
`endif
  output logic [DATA_W-1:0]   out,
  output logic                out_valid,
  output logic                busy,
  output logic                err,
  output logic [LED_W-1:0]    led
);

  localparam int AW = clog2(DEPTH);
  localparam int NB = DATA_W / 8;

  state_e            state_q, state_d;
  logic [AW-1:0]     init_cnt_q, init_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              zero_q, zero_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [LED_W-1:0]  led_wr;

  logic              legal;
  logic [NB-1:0]     wr_be;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_rdata;

`ifdef DATA_MEMORY_BYTE_WRITE_EN
  assign wr_be = byte_en;
`else
  assign wr_be = {NB{1'b1}};
`endif

  assign legal = location < ADDR_W'(DEPTH);

  // led_q always equals the low bits of word LED_ADDR, so merge against it.
  always_comb begin
    led_wr = led_q;
    for (int i = 0; i < LED_W; i++) begin
      if (wr_be[i/8]) led_wr[i] = value[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    zero_d      = zero_q;
    led_d       = led_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = location[AW-1:0];
    ram_wdata   = value;
    ram_be      = wr_be;
    unique case (state_q)
      INIT: begin
        ram_we     = 1'b1;
        ram_addr   = init_cnt_q;
        ram_wdata  = '0;
        ram_be     = '1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        out_valid_d = memRead;
        err_d = (memRead & memWrite)
              | ((memRead | memWrite) & ~legal);
        if (memRead) begin
          ram_re = legal;
          zero_d = ~legal;
        end else if (memWrite && legal) begin
          ram_we = 1'b1;
          if (location[AW-1:0] == AW'(LED_ADDR)) led_d = led_wr;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      zero_q      <= 1'b1;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      zero_q      <= zero_d;
      led_q       <= led_d;
    end
  end

  sync_ram_1p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .rdata (ram_rdata)
  );

  assign out       = zero_q ? '0 : ram_rdata;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == INIT);
  assign err       = err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed vector bench for data_memory_mmio (default parameters).
module tb_data_memory_mmio;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic        memWrite;
  logic [31:0] location;
  logic [31:0] value;
  logic [3:0]  be_r;
  logic [31:0] out;
  logic        out_valid;
  logic        busy;
  logic        err;
  logic [3:0]  led;

  int nvec;
  int nmis;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] loc;
    logic [31:0] val;
    logic [31:0] e_out;
    logic        e_vld;
    logic        e_err;
    logic [3:0]  e_led;
  } vec_t;

  vec_t vt[19];

  data_memory_mmio dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .location  (location),
    .value     (value),
`ifdef DATA_MEMORY_BYTE_WRITE_EN
    .byte_en   (be_r),
`endif
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .err       (err),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic wr,
                     input logic [31:0] loc, input logic [31:0] val);
    memRead  = rd;
    memWrite = wr;
    location = loc;
    value    = val;
    @(posedge clk);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  // Count edges until busy drops; requests at location 5 must be dropped.
  task automatic wait_init(input string name);
    int  cnt;
    logic leak;
    cnt  = 0;
    leak = 1'b0;
    memRead  = 1'b1;
    memWrite = 1'b0;
    location = 32'd5;
    while (busy && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (out_valid || err) leak = 1'b1;
    end
    memRead = 1'b0;
    chk({name, "_busy_cycles"}, 32'(cnt), 32'd256);
    chk({name, "_drop"}, 32'(leak), 32'd0);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    //             rd    wr    loc      val           out           vld   err   led
    vt[0]  = '{1'b1, 1'b0, 32'd5,   32'h0,        32'h0,        1'b1, 1'b0, 4'h0};
    vt[1]  = '{1'b0, 1'b1, 32'd3,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 4'h0};
    vt[2]  = '{1'b1, 1'b0, 32'd3,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 4'h0};
    vt[3]  = '{1'b0, 1'b0, 32'd3,   32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 4'h0};
    vt[4]  = '{1'b0, 1'b1, 32'd1,   32'h0000000A, 32'hDEADBEEF, 1'b0, 1'b0, 4'hA};
    vt[5]  = '{1'b1, 1'b0, 32'd1,   32'h0,        32'h0000000A, 1'b1, 1'b0, 4'hA};
    vt[6]  = '{1'b0, 1'b1, 32'd7,   32'h11,       32'h0000000A, 1'b0, 1'b0, 4'hA};
    vt[7]  = '{1'b1, 1'b1, 32'd7,   32'h22,       32'h11,       1'b1, 1'b1, 4'hA};
    vt[8]  = '{1'b0, 1'b0, 32'd0,   32'h0,        32'h11,       1'b0, 1'b0, 4'hA};
    vt[9]  = '{1'b1, 1'b0, 32'd7,   32'h0,        32'h11,       1'b1, 1'b0, 4'hA};
    vt[10] = '{1'b1, 1'b0, 32'd300, 32'h0,        32'h0,        1'b1, 1'b1, 4'hA};
    vt[11] = '{1'b0, 1'b1, 32'd256, 32'h55,       32'h0,        1'b0, 1'b1, 4'hA};
    vt[12] = '{1'b1, 1'b0, 32'd0,   32'h0,        32'h0,        1'b1, 1'b0, 4'hA};
    vt[13] = '{1'b1, 1'b0, 32'd3,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 4'hA};
    vt[14] = '{1'b1, 1'b0, 32'd1,   32'h0,        32'h0000000A, 1'b1, 1'b0, 4'hA};
    vt[15] = '{1'b0, 1'b1, 32'd9,   32'h12345678, 32'h0000000A, 1'b0, 1'b0, 4'hA};
    vt[16] = '{1'b1, 1'b0, 32'd9,   32'h0,        32'h12345678, 1'b1, 1'b0, 4'hA};
    vt[17] = '{1'b0, 1'b1, 32'd1,   32'h5,        32'h12345678, 1'b0, 1'b0, 4'h5};
    vt[18] = '{1'b1, 1'b1, 32'd300, 32'h0,        32'h0,        1'b1, 1'b1, 4'h5};

    rst_n    = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    location = '0;
    value    = '0;
    be_r     = 4'hF;
    #2;
    chk("rst_out", out, 32'h0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("init1");

    for (int i = 0; i < 19; i++) begin
      cyc(vt[i].rd, vt[i].wr, vt[i].loc, vt[i].val);
      chk($sformatf("v%0d_out", i), out, vt[i].e_out);
      chk($sformatf("v%0d_vld", i), 32'(out_valid), 32'(vt[i].e_vld));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_led", i), 32'(led), 32'(vt[i].e_led));
    end

    // Asynchronous reset in IDLE clears led and out without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_out", out, 32'h0);
    chk("arst_busy", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset again part-way through INIT; sequence restarts from word 0.
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_init("init2");

    cyc(1'b1, 1'b0, 32'd1, 32'h0);
    chk("post_rst_w1", out, 32'h0);
    chk("post_rst_w1_vld", 32'(out_valid), 32'd1);
    cyc(1'b1, 1'b0, 32'd3, 32'h0);
    chk("post_rst_w3", out, 32'h0);
    chk("post_rst_led", 32'(led), 32'd0);

`ifdef DATA_MEMORY_BYTE_WRITE_EN
    be_r = 4'hF;
    cyc(1'b0, 1'b1, 32'd4, 32'hFFFFFFFF);
    be_r = 4'b0101;
    cyc(1'b0, 1'b1, 32'd4, 32'h00000000);
    be_r = 4'hF;
    cyc(1'b1, 1'b0, 32'd4, 32'h0);
    chk("be_merge", out, 32'hFF00FF00);
    be_r = 4'h0;
    cyc(1'b0, 1'b1, 32'd1, 32'h0000000F);
    chk("be_zero_err", 32'(err), 32'd0);
    chk("be_zero_led", 32'(led), 32'd0);
    be_r = 4'hF;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
